data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder serving load/store requests from the processor's memory stage over a valid/ready request channel and a one-cycle response pulse. It implements the byte-, halfword- and word-granular RISC-V loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with lane steering and sign/zero extension, configurable wait states, and misaligned-access reporting. It replaces the single-cycle data memory behind the ALU address path once the core moves to a stalling memory stage.

## Interface
- ADDR_W, 8, byte-address width; storage is 2**(ADDR_W-2) 32-bit words, little-endian
- WAIT_STATES, 1, extra cycles between acceptance and commit (0..15)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on edge with req_valid & req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 width/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, low bits used for SB/SH
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid; illegal funct3 or misaligned

## Operation
- States: IDLE -> (accept) -> WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0); WAIT -> RESP after WAIT_STATES cycles; RESP -> IDLE unconditionally.
- Acceptance latches write, funct3, addr, wdata; req_* ignored outside IDLE.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Anything else -> error.
- Word index = addr[ADDR_W-1:2]; lane = addr[1:0]; full address space maps, no out-of-range case.
- Store: byte-enable write of selected lanes only; other bytes unchanged.
- Load: select lane(s), sign-extend (LB/LH) or zero-extend (LBU/LHU); LW returns word unchanged.
- Commit (memory write / read capture) happens on the edge entering RESP; a load in RESP reflects all earlier committed stores.
- Error requests: no memory change, still traverse WAIT/RESP with identical latency, rsp_err=1, rsp_rdata=0.
- Reset: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request cleared; req_ready=1 from first cycle after reset deasserts (0 while reset high). Memory contents not affected by reset.
- Reset asserted in WAIT aborts the request: no write, no response. Reset on the commit edge wins: no write.

## Timing
- Acceptance edge E0; commit at edge E0+WAIT_STATES; rsp_valid high for exactly the cycle after commit.
- Latency acceptance->response: WAIT_STATES+1 cycles; next accept earliest one cycle after rsp_valid; throughput one request per WAIT_STATES+2 cycles.
- rsp_rdata/rsp_err registered; hold their value after rsp_valid drops until the next commit.
- req_ready is a decode of registered state only (no combinational path from req_valid).

## Configuration
- DMEM_MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 -> rsp_err=1, no access.
- Undefined: low address bits forced to natural alignment (halfword clears addr[0], word clears addr[1:0]) and access proceeds; rsp_err only for illegal funct3.

## Structure
- Package dmem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding (IDLE, WAIT, RESP), wait-counter width.
- One combinational sub-module dmem_lane_align: given funct3, addr[1:0], wdata, raw word -> byte enables, steered write word, extended read data.
- Top holds FSM, wait counter, request latch, storage array.

## Test plan
- WAIT_STATES=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err=0.
- After above: SB 0x5A @0x11, then LBU @0x11 -> 0x0000005A; LW @0x10 -> 0xDEAD5AEF; LB @0x13 -> 0xFFFFFFDE.
- SH 0x8001 @0x22, LH @0x22 -> 0xFFFF8001, LHU @0x22 -> 0x00008001; word @0x20 low half unchanged.
- With DMEM_MISALIGN_CHECK_EN: LW @0x11 -> err=1, rdata 0; SH @0x23 then LW @0x20 -> word unchanged. Without: LW @0x11 returns word @0x10, err=0.
- funct3=011 load and funct3=100 store -> err=1, memory unchanged, same latency.
- Reset asserted during WAIT of SW 0x12345678 @0x30 -> no rsp_valid, LW @0x30 after reset returns prior value; req_ready=1 first cycle after reset drops.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: funct3 codes, FSM states, request latch.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_pkg;

    // RISC-V load/store width and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for WAIT_STATES up to 15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Latched request fields (the address is kept separately because its width is a parameter)
    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for byte/halfword/word accesses: byte enables, replicated store word, extended load data.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are used.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    logic [31:0] byte_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_shift = rword_i >> {lane_i, 3'b000};
    assign byte_sel   = byte_shift[7:0];
    assign half_sel   = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Byte enables and store data replicated across every lane so only be_o selects the target
    always_comb begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << lane_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            F3_H, F3_HU: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wword_o = wdata_i;
            end
        endcase
    end

    // Load data extension: signed codes replicate the top bit, unsigned codes zero-fill
    always_comb begin
        rdata_o = rword_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'h000000, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'h0000, half_sel};
            default: rdata_o = rword_i;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder with lane steering; DMEM_MISALIGN_CHECK_EN makes misaligned accesses errors.
// Latency: WAIT_STATES+1 cycles from acceptance to the one-cycle rsp_valid pulse.
// Backpressure: req_ready only in IDLE, so at most one request in flight (one per WAIT_STATES+2 cycles).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              commit;
    logic              accept;

    logic [31:0]       mem_q [DEPTH];

    // Request being committed: with zero wait states the commit happens on the
    // acceptance edge itself, so the live inputs are used while still in IDLE.
    req_t              cur_req;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-3:0] cur_idx;
    logic [1:0]        cur_lane;
    logic [1:0]        eff_lane;
    logic              cur_legal;
    logic              cur_half;
    logic              cur_word;
    logic              cur_err;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic [31:0]       ext_rdata;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign cur_req  = (state_q == IDLE) ? '{write: req_write, funct3: req_funct3, wdata: req_wdata} : req_q;
    assign cur_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign cur_idx  = cur_addr[ADDR_W-1:2];
    assign cur_lane = cur_addr[1:0];
    assign cur_half = (cur_req.funct3[1:0] == 2'b01);
    assign cur_word = (cur_req.funct3[1:0] == 2'b10);

    // Stores only have signed-looking codes; loads additionally accept the unsigned variants
    always_comb begin
        cur_legal = 1'b0;
        if (cur_req.write) begin
            cur_legal = (cur_req.funct3 == F3_B) || (cur_req.funct3 == F3_H) || (cur_req.funct3 == F3_W);
        end else begin
            cur_legal = (cur_req.funct3 == F3_B)  || (cur_req.funct3 == F3_H) || (cur_req.funct3 == F3_W) ||
                        (cur_req.funct3 == F3_BU) || (cur_req.funct3 == F3_HU);
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    // Misaligned halfword/word accesses are reported and never touch memory
    assign cur_err  = !cur_legal || (cur_half && cur_lane[0]) || (cur_word && (cur_lane != 2'b00));
    assign eff_lane = cur_lane;
`else
    // Low address bits are dropped to natural alignment and the access goes ahead
    assign cur_err  = !cur_legal;
    assign eff_lane = cur_word ? 2'b00 : (cur_half ? {cur_lane[1], 1'b0} : cur_lane);
`endif

    dmem_lane_align u_lane_align (
        .funct3_i (cur_req.funct3),
        .lane_i   (eff_lane),
        .wdata_i  (cur_req.wdata),
        .rword_i  (mem_q[cur_idx]),
        .be_o     (be),
        .wword_o  (wword),
        .rdata_o  (ext_rdata)
    );

    // Next-state logic: accept in IDLE, count wait states, commit on the edge into RESP
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        addr_d      = addr_q;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d  = cur_req;
                    addr_d = req_addr;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response data is captured at commit and held until the next commit
    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (commit) begin
            rsp_err_d   = cur_err;
            rsp_rdata_d = (cur_err || cur_req.write) ? 32'h0 : ext_rdata;
        end
    end

    // Control and response registers, synchronously cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            addr_q      <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage: byte-enabled writes on commit; reset blocks a commit on the same edge but never clears contents
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_req.write && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[cur_idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with WAIT_STATES=1; expectations follow DMEM_MISALIGN_CHECK_EN.
// Latency: each request expects rsp_valid two cycles after acceptance.
// Backpressure: requests are held until req_ready is seen.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_vec = 0;
    int n_err = 0;

    data_mem_responder #(.ADDR_W(8), .WAIT_STATES(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for its response; lat=0 means no response seen
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 8'h10;
        req_wdata  = 32'h0BADBAD0;
        lat = 0;
        rd  = 32'h0;
        er  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'b000;
        req_addr  = 8'h00;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 00000000", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", rsp_err); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, rd, er, lat);
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL sw10_latency got %0d exp %0d", lat, LAT); end
        n_vec++; if (er !== 1'b0 || rd !== 32'h0) begin n_err++; $display("FAIL sw10_rsp got err=%b rdata=%h exp err=0 rdata=00000000", er, rd); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL resp_ready got %b exp 0", req_ready); end
        do_req(1'b0, 3'b010, 8'h10, 32'h0, rd, er, lat);
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL lw10_latency got %0d exp %0d", lat, LAT); end
        n_vec++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_err++; $display("FAIL lw10_rdata got %h err=%b exp deadbeef err=0", rd, er); end
        @(negedge clk);
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_pulse_width got %b exp 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rdata_hold got %h exp deadbeef", rsp_rdata); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b000, 8'h11, 32'hFFFFFF5A, rd, er, lat);
        n_vec++; if (lat !== LAT || er !== 1'b0) begin n_err++; $display("FAIL sb11 got lat=%0d err=%b exp lat=%0d err=0", lat, er, LAT); end
        do_req(1'b0, 3'b100, 8'h11, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'h0000005A) begin n_err++; $display("FAIL lbu11 got %h exp 0000005a", rd); end
        do_req(1'b0, 3'b010, 8'h10, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'hDEAD5AEF) begin n_err++; $display("FAIL lw10_after_sb got %h exp dead5aef", rd); end
        do_req(1'b0, 3'b000, 8'h13, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'hFFFFFFDE) begin n_err++; $display("FAIL lb13 got %h exp ffffffde", rd); end
        do_req(1'b0, 3'b000, 8'h10, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'hFFFFFFEF) begin n_err++; $display("FAIL lb10 got %h exp ffffffef", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 8'h20, 32'h11223344, rd, er, lat);
        do_req(1'b1, 3'b001, 8'h22, 32'hFFFF8001, rd, er, lat);
        n_vec++; if (lat !== LAT || er !== 1'b0) begin n_err++; $display("FAIL sh22 got lat=%0d err=%b exp lat=%0d err=0", lat, er, LAT); end
        do_req(1'b0, 3'b001, 8'h22, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'hFFFF8001) begin n_err++; $display("FAIL lh22 got %h exp ffff8001", rd); end
        do_req(1'b0, 3'b101, 8'h22, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'h00008001) begin n_err++; $display("FAIL lhu22 got %h exp 00008001", rd); end
        do_req(1'b0, 3'b010, 8'h20, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'h80013344) begin n_err++; $display("FAIL lw20_after_sh got %h exp 80013344", rd); end
        do_req(1'b0, 3'b001, 8'h20, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'h00003344) begin n_err++; $display("FAIL lh20 got %h exp 00003344", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
`ifdef DMEM_MISALIGN_CHECK_EN
        do_req(1'b0, 3'b010, 8'h11, 32'h0, rd, er, lat);
        n_vec++; if (er !== 1'b1 || rd !== 32'h0 || lat !== LAT) begin n_err++; $display("FAIL lw11_misalign got err=%b rdata=%h lat=%0d exp err=1 rdata=00000000 lat=%0d", er, rd, lat, LAT); end
        do_req(1'b1, 3'b001, 8'h23, 32'h0000BEEF, rd, er, lat);
        n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL sh23_misalign got err=%b exp 1", er); end
        do_req(1'b0, 3'b010, 8'h20, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'h80013344) begin n_err++; $display("FAIL lw20_after_bad_sh got %h exp 80013344", rd); end
`else
        do_req(1'b0, 3'b010, 8'h11, 32'h0, rd, er, lat);
        n_vec++; if (er !== 1'b0 || rd !== 32'hDEAD5AEF || lat !== LAT) begin n_err++; $display("FAIL lw11_aligned got err=%b rdata=%h lat=%0d exp err=0 rdata=dead5aef lat=%0d", er, rd, lat, LAT); end
        do_req(1'b1, 3'b001, 8'h23, 32'h0000BEEF, rd, er, lat);
        n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL sh23_aligned got err=%b exp 0", er); end
        do_req(1'b0, 3'b010, 8'h20, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'hBEEF3344) begin n_err++; $display("FAIL lw20_after_sh23 got %h exp beef3344", rd); end
`endif
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 3'b011, 8'h10, 32'h0, rd, er, lat);
        n_vec++; if (er !== 1'b1 || rd !== 32'h0 || lat !== LAT) begin n_err++; $display("FAIL load_f3_011 got err=%b rdata=%h lat=%0d exp err=1 rdata=00000000 lat=%0d", er, rd, lat, LAT); end
        do_req(1'b1, 3'b100, 8'h10, 32'hFFFFFFFF, rd, er, lat);
        n_vec++; if (er !== 1'b1 || rd !== 32'h0 || lat !== LAT) begin n_err++; $display("FAIL store_f3_100 got err=%b rdata=%h lat=%0d exp err=1 rdata=00000000 lat=%0d", er, rd, lat, LAT); end
        do_req(1'b0, 3'b010, 8'h10, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'hDEAD5AEF || er !== 1'b0) begin n_err++; $display("FAIL lw10_after_illegal got %h err=%b exp dead5aef err=0", rd, er); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 3'b010, 8'h30, 32'hCAFEF00D, rd, er, lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 8'h30;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL abort_wait_valid got %b exp 0", rsp_valid); end
        @(negedge clk);
        n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_reset got valid=%b ready=%b exp valid=0 ready=0", rsp_valid, req_ready); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL abort_release got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid); end
        do_req(1'b0, 3'b010, 8'h30, 32'h0, rd, er, lat);
        n_vec++; if (rd !== 32'hCAFEF00D || lat !== LAT) begin n_err++; $display("FAIL lw30_after_abort got %h lat=%0d exp cafef00d lat=%0d", rd, lat, LAT); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_illegal();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
